// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: command/state encodings and default sizes shared by the run controller
package cpu_run_ctrl_pkg;
    typedef enum logic [1:0] {
        CMD_STOP  = 2'b00,
        CMD_STEP  = 2'b01,
        CMD_RUN   = 2'b10,
        CMD_RESET = 2'b11
    } cmd_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STEP = 2'b01,
        ST_RUN  = 2'b10,
        ST_RST  = 2'b11
    } state_e;
    localparam int DEF_DIV_W      = 26;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_RST_CYCLES = 4;
endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: monitor command bus plus core status/enable signals of the run controller
interface cpu_run_ctrl_if
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd;
    logic [DIV_W-1:0]  rate;
    logic              end_sq;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_valid;
    logic              cpu_ce;
    logic              cpu_reset;
    logic [1:0]        state;
    logic              bp_hit;
    modport master (
        output cmd_valid, cmd, rate, end_sq, halt, pc, bp_addr, bp_valid,
        input  cmd_ready, cpu_ce, cpu_reset, state, bp_hit
    );
    modport slave (
        input  cmd_valid, cmd, rate, end_sq, halt, pc, bp_addr, bp_valid,
        output cmd_ready, cpu_ce, cpu_reset, state, bp_hit
    );
endinterface

// File: rtl/cpu_run_ctrl_tick_gen.sv
// tick_gen: reloadable down-counter producing a tick every rate+1 enabled cycles
module tick_gen #(
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_rate,
    input  logic             i_en,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_reload;

    assign o_tick = i_en && r_cnt == '0;

    // latch the rate on load so later changes on the input are ignored until the next load
    always_ff @(posedge clk)
        if (rst) begin
            r_cnt    <= '0;
            r_reload <= '0;
        end else if (i_load) begin
            r_cnt    <= i_rate;
            r_reload <= i_rate;
        end else if (i_en)
            r_cnt <= o_tick ? r_reload : r_cnt - DIV_W'(1);
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: STOP/STEP/RUN/RESET_CPU sequencer gating the CDECv core with a 1-cycle clock enable
// Optional PC breakpoint stop in RUN is built when CPU_RUN_BREAKPOINT_EN is defined.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIV_W      = DEF_DIV_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic clk,
    input  logic rst,
    cpu_run_ctrl_if.slave bus
);
    localparam int RW = $clog2(RST_CYCLES + 1);

    state_e        r_state;
    state_e        w_next;
    cmd_e          w_cmd;
    logic          w_accept;
    logic          w_stop_cmd;
    logic          w_rst_cmd;
    logic          w_load;
    logic          w_tick;
    logic          w_bnd;
    logic          w_bp_stop;
    logic          w_ce_next;
    logic          r_ce;
    logic          r_cpu_reset;
    logic [RW-1:0] r_rst_cnt;

    assign w_cmd         = cmd_e'(bus.cmd);
    assign bus.cmd_ready = r_state == ST_IDLE || r_state == ST_RUN;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;
    assign w_stop_cmd    = w_accept && w_cmd == CMD_STOP;
    assign w_rst_cmd     = w_accept && w_cmd == CMD_RESET;
    assign w_load        = w_accept && r_state == ST_IDLE && (w_cmd == CMD_STEP || w_cmd == CMD_RUN);
    assign w_bnd         = r_ce && bus.end_sq;
    assign bus.cpu_ce    = r_ce;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.state     = r_state;

    tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_rate (bus.rate),
        .i_en   (r_state == ST_STEP || r_state == ST_RUN),
        .o_tick (w_tick)
    );

`ifdef CPU_RUN_BREAKPOINT_EN
    logic r_bnd;
    logic r_bp_hit;

    assign w_bp_stop  = r_bnd && r_state == ST_RUN && bus.bp_valid && bus.pc == bus.bp_addr;
    assign bus.bp_hit = r_bp_hit;

    // compare the PC one cycle after a RUN boundary, once the core has advanced it; STOP/RESET/halt outrank the hit
    always_ff @(posedge clk)
        if (rst) begin
            r_bnd    <= 1'b0;
            r_bp_hit <= 1'b0;
        end else begin
            r_bnd    <= r_state == ST_RUN && w_bnd;
            r_bp_hit <= (w_bp_stop && !w_stop_cmd && !w_rst_cmd && !bus.halt) || (r_bp_hit && !w_accept);
        end
`else
    assign w_bp_stop  = 1'b0;
    assign bus.bp_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk)
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;

    // next state, priority RESET_CPU > STOP > halt > breakpoint > tick
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = !w_accept           ? ST_IDLE :
                              w_cmd == CMD_STEP   ? ST_STEP :
                              w_cmd == CMD_RUN    ? ST_RUN  :
                              w_cmd == CMD_RESET  ? ST_RST  : ST_IDLE;
            ST_STEP: w_next = (bus.halt || w_bnd) ? ST_IDLE : ST_STEP;
            ST_RUN:  w_next = w_rst_cmd ? ST_RST :
                              (w_stop_cmd || bus.halt || w_bp_stop) ? ST_IDLE : ST_RUN;
            ST_RST:  w_next = r_rst_cnt == '0 ? ST_IDLE : ST_RST;
            default: w_next = ST_IDLE;
        endcase
    end

    // a tick becomes a core enable only when nothing is pulling us out of STEP/RUN this cycle
    always_comb w_ce_next = w_tick && w_next == r_state;

    // registered core enable, core reset and RST-length counter
    always_ff @(posedge clk)
        if (rst) begin
            r_ce        <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_rst_cnt   <= '0;
        end else begin
            r_ce        <= w_ce_next;
            r_cpu_reset <= w_next == ST_RST;
            r_rst_cnt   <= r_state != ST_RST ? RW'(RST_CYCLES - 1) : r_rst_cnt - RW'(1);
        end
endmodule
